axis_accel_sel_ctrl: RTL and testbench
======================================

AXIS_ACCEL_SEL_CTRL -- requirements
Module: axis_accel_sel_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of beat counters and beat_count.
REQ-002 Parameter: TIMEOUT, 1048576, idle cycles in RUN/DRAIN before forced completion.
REQ-003 Port: ap_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: ap_rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: start_req  in  1  single-cycle request to launch one job.
REQ-006 Port: mode_req  in  1  requested mode (1=encoder, 0=decoder), sampled with start_req.
REQ-007 Port: beat_count  in  CNT_W  expected output beats for the job; sampled with start_req.
REQ-008 Port: in_V_TVALID, in_V_TREADY  in  1 each  monitor taps of the selector's input stream.
REQ-009 Port: out_V_TVALID, out_V_TREADY  in  1 each  monitor taps of the selector's output stream.
REQ-010 Port: ap_done  in  1  done from the selector (muxed accelerator done).
REQ-011 Port: USE_ENC  out  1  registered mode select driving the selector.
REQ-012 Port: ap_start  out  1  start to the selector.
REQ-013 Port: busy  out  1  high in any state other than IDLE.
REQ-014 Port: start_rej  out  1  one-cycle pulse: start_req arrived while not IDLE.
REQ-015 Port: job_done  out  1  one-cycle completion pulse.
REQ-016 Port: timeout  out  1  sticky-per-job flag: last job ended by watchdog.
REQ-017 Port: in_beats, out_beats  out  CNT_W each  handshake counts of current/last job.

Function
REQ-018 States: IDLE, START, RUN, DRAIN, DONE; encoding free, one-hot or binary.
REQ-019 IDLE + start_req: latch mode_req into USE_ENC, latch beat_count, clear in_beats/out_beats/timeout/watchdog; next state START.
REQ-020 USE_ENC SHALL change only on the IDLE start-accept edge; stable for the whole job and after it.
REQ-021 start_req in any non-IDLE state: ignored, start_rej=1 next cycle for one cycle; no state or register change.
REQ-022 START lasts exactly one cycle, then RUN; ap_start=1 in START and RUN, 0 elsewhere (registered, no glitch).
REQ-023 in_beats +1 per cycle with in_V_TVALID&in_V_TREADY in START/RUN/DRAIN; out_beats likewise on out_V handshake; both saturate at all-ones.
REQ-024 RUN + ap_done=1: go DRAIN; ap_start drops the next cycle.
REQ-025 DRAIN -> DONE when out_beats (counting a same-cycle beat) >= latched beat_count; beat_count=0 leaves DRAIN after one cycle.
REQ-026 ap_done and final out beat in same RUN cycle: beat counted; DRAIN lasts one cycle then DONE.
REQ-027 Watchdog: counts cycles in RUN/DRAIN, clears on any in/out handshake or state change; on reaching TIMEOUT go DONE with timeout=1.
REQ-028 DONE lasts one cycle: job_done=1; next state IDLE; counters and timeout hold until next accepted start.
REQ-029 start_req in DONE is rejected (REQ-021); only IDLE accepts.

Reset
REQ-030 ap_rst=1 immediately forces IDLE; USE_ENC=0, ap_start=0, busy=0, start_rej=0, job_done=0, timeout=0, in_beats=0, out_beats=0, watchdog=0.
REQ-031 Reset mid-job aborts without job_done pulse; first start_req after release is accepted normally.

Verification
REQ-032 Encode job: mode_req=1, beat_count=4, 4 in and 4 out beats, ap_done after last out beat -> USE_ENC=1, ap_start high START..RUN, job_done once, in_beats=4, out_beats=4, timeout=0.
REQ-033 Decode drain: mode_req=0, beat_count=3, ap_done after 1 out beat, 2 more later -> DRAIN holds until 3rd beat, ap_start low in DRAIN, USE_ENC=0.
REQ-034 Busy reject: start_req with mode_req=0 during RUN of encode job -> start_rej one cycle, USE_ENC stays 1, job unaffected.
REQ-035 Timeout: TIMEOUT=16, ap_done never asserted, no handshakes -> DONE 16 cycles after last activity, timeout=1, job_done pulse.
REQ-036 Reset mid-RUN: ap_rst asserted asynchronously -> ap_start/busy/USE_ENC=0 before next edge, no job_done; subsequent job completes normally.
REQ-037 Coincidence: ap_done and last out beat same cycle, beat_count=2 -> out_beats=2, one DRAIN cycle, job_done next.

Source files
------------

// File: rtl/axis_accel_sel_ctrl.sv
// Job controller for the encoder/decoder stream selector: launches one job,
// tracks stream beats, waits for the output to drain and guards against stalls.
module axis_accel_sel_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1048576
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             start_req,
    input  logic             mode_req,
    input  logic [CNT_W-1:0] beat_count,
    input  logic             in_V_TVALID,
    input  logic             in_V_TREADY,
    input  logic             out_V_TVALID,
    input  logic             out_V_TREADY,
    input  logic             ap_done,
    output logic             USE_ENC,
    output logic             ap_start,
    output logic             busy,
    output logic             start_rej,
    output logic             job_done,
    output logic             timeout,
    output logic [CNT_W-1:0] in_beats,
    output logic [CNT_W-1:0] out_beats
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] beat_lat;
    logic [CNT_W-1:0] in_inc;
    logic [CNT_W-1:0] out_inc;
    logic [CNT_W-1:0] out_nxt;
    logic [WD_W-1:0]  wdog;
    logic             in_hs;
    logic             out_hs;
    logic             counting;
    logic             active;
    logic             accept;
    logic             wd_expire;
    logic             set_timeout;

    always_comb begin
        in_hs       = in_V_TVALID & in_V_TREADY;
        out_hs      = out_V_TVALID & out_V_TREADY;
        counting    = (state == START) || (state == RUN) || (state == DRAIN);
        active      = (state == RUN) || (state == DRAIN);
        accept      = (state == IDLE) && start_req;
        in_inc      = (&in_beats) ? in_beats : in_beats + CNT_W'(1);
        out_inc     = (&out_beats) ? out_beats : out_beats + CNT_W'(1);
        // Drain exit must see a beat landing in the same cycle.
        out_nxt     = (counting && out_hs) ? out_inc : out_beats;
        wd_expire   = active && !in_hs && !out_hs && (wdog == WD_LAST);
        set_timeout = 1'b0;
        next_state  = state;
        case (state)
            IDLE:    if (start_req) next_state = START;
            START:   next_state = RUN;
            RUN: begin
                if (ap_done) begin
                    next_state = DRAIN;
                end else if (wd_expire) begin
                    next_state  = DONE;
                    set_timeout = 1'b1;
                end
            end
            DRAIN: begin
                if (out_nxt >= beat_lat) begin
                    next_state = DONE;
                end else if (wd_expire) begin
                    next_state  = DONE;
                    set_timeout = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they never glitch.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            USE_ENC   <= 1'b0;
            ap_start  <= 1'b0;
            busy      <= 1'b0;
            start_rej <= 1'b0;
            job_done  <= 1'b0;
            timeout   <= 1'b0;
            in_beats  <= '0;
            out_beats <= '0;
            beat_lat  <= '0;
            wdog      <= '0;
        end else begin
            state     <= next_state;
            ap_start  <= (next_state == START) || (next_state == RUN);
            busy      <= (next_state != IDLE);
            job_done  <= (next_state == DONE);
            start_rej <= start_req && (state != IDLE);
            if (accept) begin
                USE_ENC   <= mode_req;
                beat_lat  <= beat_count;
                in_beats  <= '0;
                out_beats <= '0;
                timeout   <= 1'b0;
                wdog      <= '0;
            end else begin
                if (counting && in_hs) in_beats <= in_inc;
                out_beats <= out_nxt;
                if (set_timeout) timeout <= 1'b1;
                if (active && (next_state == state) && !in_hs && !out_hs)
                    wdog <= wdog + WD_W'(1);
                else
                    wdog <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_accel_sel_ctrl.sv
// Scoreboard bench: expected job results are queued at start and compared on job_done.
module tb_axis_accel_sel_ctrl;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    logic             ap_clk;
    logic             ap_rst;
    logic             start_req;
    logic             mode_req;
    logic [CNT_W-1:0] beat_count;
    logic             in_V_TVALID;
    logic             in_V_TREADY;
    logic             out_V_TVALID;
    logic             out_V_TREADY;
    logic             ap_done;
    logic             USE_ENC;
    logic             ap_start;
    logic             busy;
    logic             start_rej;
    logic             job_done;
    logic             timeout;
    logic [CNT_W-1:0] in_beats;
    logic [CNT_W-1:0] out_beats;

    typedef struct {
        logic        use_enc;
        logic [31:0] in_n;
        logic [31:0] out_n;
        logic        to;
    } job_exp_t;

    job_exp_t sb[$];
    job_exp_t exp_job;
    int       n_compared;
    int       n_mismatched;
    int       done_cnt;
    int       done_before;
    int       n_cyc;

    axis_accel_sel_ctrl #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .start_req   (start_req),
        .mode_req    (mode_req),
        .beat_count  (beat_count),
        .in_V_TVALID (in_V_TVALID),
        .in_V_TREADY (in_V_TREADY),
        .out_V_TVALID(out_V_TVALID),
        .out_V_TREADY(out_V_TREADY),
        .ap_done     (ap_done),
        .USE_ENC     (USE_ENC),
        .ap_start    (ap_start),
        .busy        (busy),
        .start_rej   (start_rej),
        .job_done    (job_done),
        .timeout     (timeout),
        .in_beats    (in_beats),
        .out_beats   (out_beats)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic mode, input logic [31:0] bc,
                                 input bit push, input logic [31:0] exp_in,
                                 input logic [31:0] exp_out, input logic exp_to);
        job_exp_t e;
        start_req  = 1'b1;
        mode_req   = mode;
        beat_count = bc;
        if (push) begin
            e.use_enc = mode;
            e.in_n    = exp_in;
            e.out_n   = exp_out;
            e.to      = exp_to;
            sb.push_back(e);
        end
        tick();
        start_req = 1'b0;
    endtask

    task automatic setIn(input logic v);
        in_V_TVALID = v;
        in_V_TREADY = v;
    endtask

    task automatic setOut(input logic v);
        out_V_TVALID = v;
        out_V_TREADY = v;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!job_done && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 32'(job_done), 1);
    endtask

    always @(negedge ap_clk) begin
        if (!ap_rst && job_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_job = sb.pop_front();
                checkOutput("job_use_enc", 32'(USE_ENC), 32'(exp_job.use_enc));
                checkOutput("job_in_beats", in_beats, exp_job.in_n);
                checkOutput("job_out_beats", out_beats, exp_job.out_n);
                checkOutput("job_timeout", 32'(timeout), 32'(exp_job.to));
            end
        end
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        done_cnt     = 0;
        ap_rst       = 1'b0;
        start_req    = 1'b0;
        mode_req     = 1'b0;
        beat_count   = '0;
        ap_done      = 1'b0;
        setIn(1'b0);
        setOut(1'b0);
        #2 ap_rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_use_enc", 32'(USE_ENC), 0);
        checkOutput("rst_ap_start", 32'(ap_start), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_start_rej", 32'(start_rej), 0);
        checkOutput("rst_job_done", 32'(job_done), 0);
        checkOutput("rst_timeout", 32'(timeout), 0);
        checkOutput("rst_in_beats", in_beats, 0);
        checkOutput("rst_out_beats", out_beats, 0);
        ap_rst = 1'b0;
        tick();

        // Encode job with a rejected start in the middle of RUN
        done_before = done_cnt;
        applyStimulus(1'b1, 4, 1'b1, 4, 4, 1'b0);
        checkOutput("enc_start_ap_start", 32'(ap_start), 1);
        checkOutput("enc_start_busy", 32'(busy), 1);
        checkOutput("enc_use_enc", 32'(USE_ENC), 1);
        setIn(1'b1);
        repeat (4) tick();
        setIn(1'b0);
        checkOutput("enc_in_beats", in_beats, 4);
        start_req = 1'b1;
        mode_req  = 1'b0;
        tick();
        start_req = 1'b0;
        checkOutput("rej_pulse", 32'(start_rej), 1);
        checkOutput("rej_use_enc", 32'(USE_ENC), 1);
        checkOutput("rej_ap_start", 32'(ap_start), 1);
        tick();
        checkOutput("rej_pulse_end", 32'(start_rej), 0);
        setOut(1'b1);
        repeat (4) tick();
        setOut(1'b0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        checkOutput("enc_drain_ap_start", 32'(ap_start), 0);
        checkOutput("enc_drain_busy", 32'(busy), 1);
        waitDone(10);
        tick();
        tick();
        checkOutput("enc_done_once", done_cnt - done_before, 1);
        checkOutput("enc_idle_busy", 32'(busy), 0);

        // Decode job whose output drains after ap_done
        applyStimulus(1'b0, 3, 1'b1, 2, 3, 1'b0);
        checkOutput("dec_use_enc", 32'(USE_ENC), 0);
        setIn(1'b1);
        repeat (2) tick();
        setIn(1'b0);
        setOut(1'b1);
        tick();
        setOut(1'b0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        repeat (3) tick();
        checkOutput("dec_drain_ap_start", 32'(ap_start), 0);
        checkOutput("dec_drain_busy", 32'(busy), 1);
        checkOutput("dec_drain_hold", 32'(job_done), 0);
        setOut(1'b1);
        tick();
        setOut(1'b0);
        repeat (3) tick();
        checkOutput("dec_drain_hold2", 32'(job_done), 0);
        checkOutput("dec_out_beats_mid", out_beats, 2);
        setOut(1'b1);
        tick();
        setOut(1'b0);
        waitDone(5);
        tick();

        // ap_done coincides with the last out beat, then a start in DONE is refused
        applyStimulus(1'b1, 2, 1'b1, 2, 2, 1'b0);
        setIn(1'b1);
        repeat (2) tick();
        setIn(1'b0);
        setOut(1'b1);
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        setOut(1'b0);
        checkOutput("coin_out_beats", out_beats, 2);
        checkOutput("coin_drain_ap_start", 32'(ap_start), 0);
        checkOutput("coin_drain_no_done", 32'(job_done), 0);
        tick();
        checkOutput("coin_done_next", 32'(job_done), 1);
        start_req = 1'b1;
        mode_req  = 1'b0;
        tick();
        start_req = 1'b0;
        checkOutput("done_rej_pulse", 32'(start_rej), 1);
        checkOutput("done_rej_busy", 32'(busy), 0);
        checkOutput("done_rej_use_enc", 32'(USE_ENC), 1);
        tick();

        // Watchdog ends a stalled job
        applyStimulus(1'b0, 5, 1'b1, 1, 0, 1'b1);
        tick();
        setIn(1'b1);
        tick();
        setIn(1'b0);
        n_cyc = 0;
        while (!job_done && n_cyc < 40) begin
            tick();
            n_cyc++;
        end
        checkOutput("to_latency", n_cyc, TIMEOUT);
        tick();
        checkOutput("to_sticky", 32'(timeout), 1);
        checkOutput("to_idle_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of RUN aborts the job silently
        done_before = done_cnt;
        applyStimulus(1'b1, 4, 1'b0, 0, 0, 1'b0);
        tick();
        setIn(1'b1);
        tick();
        setIn(1'b0);
        checkOutput("pre_rst_use_enc", 32'(USE_ENC), 1);
        #2 ap_rst = 1'b1;
        #1;
        checkOutput("async_rst_ap_start", 32'(ap_start), 0);
        checkOutput("async_rst_busy", 32'(busy), 0);
        checkOutput("async_rst_use_enc", 32'(USE_ENC), 0);
        checkOutput("async_rst_in_beats", in_beats, 0);
        tick();
        ap_rst = 1'b0;
        repeat (3) tick();
        checkOutput("rst_no_done", done_cnt - done_before, 0);

        // First job after reset, with a zero beat_count
        applyStimulus(1'b1, 0, 1'b1, 0, 0, 1'b0);
        checkOutput("post_rst_accept", 32'(busy), 1);
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        waitDone(3);
        tick();
        checkOutput("post_rst_done_cnt", done_cnt - done_before, 1);
        checkOutput("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
